// File: rtl/seg_to_hex_capture_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : seg_pkg                                                        |
// | Purpose : Shared types and constants for seg_to_hex_capture. Holds the   |
// |           7-bit segment type, the sixteen legal digit patterns, the      |
// |           BLANK pattern and the capture FSM state encoding.              |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package seg_pkg;

   // Bit 0 = segment a ... bit 6 = segment g.
   typedef logic [6:0] seg_t;

   typedef enum logic [0:0] {
      ST_UNSTABLE = 1'b0,
      ST_LOCKED   = 1'b1
   } state_t;

   // Patterns are written as a..g left to right; this reverses them so that
   // segment a lands in bit 0.
   function automatic seg_t seg_abcdefg(input logic [6:0] s);
      return {s[0], s[1], s[2], s[3], s[4], s[5], s[6]};
   endfunction

   localparam seg_t SEG_0     = seg_abcdefg(7'b1111110);
   localparam seg_t SEG_1     = seg_abcdefg(7'b0110000);
   localparam seg_t SEG_2     = seg_abcdefg(7'b1101101);
   localparam seg_t SEG_3     = seg_abcdefg(7'b1111001);
   localparam seg_t SEG_4     = seg_abcdefg(7'b0110011);
   localparam seg_t SEG_5     = seg_abcdefg(7'b1011011);
   localparam seg_t SEG_6     = seg_abcdefg(7'b1011111);
   localparam seg_t SEG_7     = seg_abcdefg(7'b1110000);
   localparam seg_t SEG_8     = seg_abcdefg(7'b1111111);
   localparam seg_t SEG_9     = seg_abcdefg(7'b1110011);
   localparam seg_t SEG_A     = seg_abcdefg(7'b1110111);
   localparam seg_t SEG_B     = seg_abcdefg(7'b0011111);
   localparam seg_t SEG_C     = seg_abcdefg(7'b1001110);
   localparam seg_t SEG_D     = seg_abcdefg(7'b0111101);
   localparam seg_t SEG_E     = seg_abcdefg(7'b1001111);
   localparam seg_t SEG_F     = seg_abcdefg(7'b1000111);
   localparam seg_t SEG_BLANK = 7'b0000000;

   // Entry i holds the pattern for hex digit i.
   localparam logic [15:0][6:0] SEG_TABLE = {
      SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
      SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
   };

endpackage : seg_pkg
`default_nettype wire

// File: rtl/seg_to_hex_capture_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : seg_to_hex_capture_if                                        |
// | Purpose   : Segment input plus decoded-digit valid/ready channel and     |
// |             status flags of seg_to_hex_capture.                          |
// | Signals   : SEV   [6:0] segment pattern (bit 0 = a)                      |
// |             HEX   [3:0] decoded digit, valid while VALID                 |
// |             VALID       decoded digit pending                            |
// |             READY       consumer accepts HEX when VALID && READY         |
// |             ERR         one-cycle pulse on an accepted illegal pattern   |
// |             OVF         sticky: a legal digit was dropped                |
// | Modports  : master - pattern source / digit consumer                     |
// |             slave  - the capture block                                   |
// | Rev       : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface seg_to_hex_capture_if;
   import seg_pkg::*;

   seg_t       SEV;
   logic [3:0] HEX;
   logic       VALID;
   logic       READY;
   logic       ERR;
   logic       OVF;

   modport master (output SEV, output READY,
                   input  HEX, input VALID, input ERR, input OVF);

   modport slave  (input  SEV, input READY,
                   output HEX, output VALID, output ERR, output OVF);

endinterface : seg_to_hex_capture_if
`default_nettype wire

// File: rtl/seg_to_hex_capture_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seg_decode                                                     |
// | Purpose : Combinational seven-segment to hex decoder.                    |
// | Ports   : seg_i   [6:0] pattern (bit 0 = a)                              |
// |           hit_o         pattern is one of the sixteen legal digits       |
// |           blank_o       pattern is all segments off                      |
// |           value_o [3:0] digit value, 0 when hit_o is low                 |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module seg_decode
   import seg_pkg::*;
(
   input  seg_t       seg_i,
   output logic       hit_o,
   output logic       blank_o,
   output logic [3:0] value_o
);

   always_comb begin
      hit_o   = 1'b0;
      value_o = 4'h0;
      blank_o = (seg_i == SEG_BLANK);
      for (int i = 0; i < 16; i++) begin
         if (!hit_o && (seg_i == SEG_TABLE[i])) begin
            hit_o   = 1'b1;
            value_o = i[3:0];
         end
      end
   end

endmodule : seg_decode
`default_nettype wire

// File: rtl/seg_to_hex_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : seg_to_hex_capture                                             |
// | Purpose : Debounces a seven-segment pattern, decodes it once it has been |
// |           stable for STABLE_CYCLES samples and offers the digit on a     |
// |           valid/ready channel. Illegal patterns pulse ERR; digits that   |
// |           arrive while one is still pending are dropped and set OVF.     |
// | Params  : STABLE_CYCLES  identical samples needed to accept (1..255)     |
// | Ports   : CLK  clock, rising edge                                        |
// |           RST  synchronous active-high reset                             |
// |           bus  seg_to_hex_capture_if.slave (SEV/HEX/VALID/READY/ERR/OVF) |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module seg_to_hex_capture
   import seg_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
)(
   input  wire                 CLK,
   input  wire                 RST,
   seg_to_hex_capture_if.slave bus
);

   localparam int               RUN_W   = $clog2(STABLE_CYCLES + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

   seg_t             prev_q;
   logic [RUN_W-1:0] run_q,   run_d;
   state_t           state_q, state_d;
   logic [3:0]       hex_q,   hex_d;
   logic             valid_q, valid_d;
   logic             err_q,   err_d;
   logic             ovf_q,   ovf_d;

   logic             sev_change;
   logic             accept;
   logic             dec_hit;
   logic             dec_blank;
   logic [3:0]       dec_value;

   seg_decode u_decode (
      .seg_i   (bus.SEV),
      .hit_o   (dec_hit),
      .blank_o (dec_blank),
      .value_o (dec_value)
   );

   // Run counter and FSM next state.
   always_comb begin
      sev_change = (bus.SEV != prev_q);
      run_d      = run_q;
      state_d    = state_q;

      if (sev_change) begin
         run_d = RUN_W'(1);
      end else if (run_q != RUN_MAX) begin
         run_d = run_q + 1'b1;
      end

      // Acceptance looks at the post-edge run length so that a pattern first
      // sampled on edge 1 is taken on edge STABLE_CYCLES.
      accept = (state_q == ST_UNSTABLE) && (run_d == RUN_MAX);

      case (state_q)
         ST_UNSTABLE: if (accept)     state_d = ST_LOCKED;
         ST_LOCKED:   if (sev_change) state_d = ST_UNSTABLE;
         default:                     state_d = ST_UNSTABLE;
      endcase
   end

   // Output channel next state.
   always_comb begin
      hex_d   = hex_q;
      valid_d = valid_q;
      err_d   = 1'b0;
      ovf_d   = ovf_q;

      if (valid_q && bus.READY) begin
         valid_d = 1'b0;
      end

      if (accept && dec_hit) begin
         // A handshake on this edge frees the slot for the new digit.
         if (!valid_q || bus.READY) begin
            hex_d   = dec_value;
            valid_d = 1'b1;
         end else begin
            ovf_d   = 1'b1;
         end
      end else if (accept && !dec_blank) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         prev_q  <= SEG_BLANK;
         run_q   <= '0;
         state_q <= ST_UNSTABLE;
         hex_q   <= 4'h0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         prev_q  <= bus.SEV;
         run_q   <= run_d;
         state_q <= state_d;
         hex_q   <= hex_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.HEX   = hex_q;
   assign bus.VALID = valid_q;
   assign bus.ERR   = err_q;
   assign bus.OVF   = ovf_q;

endmodule : seg_to_hex_capture
`default_nettype wire

// File: tb/tb_seg_to_hex_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_seg_to_hex_capture                                          |
// | Purpose : Directed scoreboard bench for seg_to_hex_capture               |
// |           (STABLE_CYCLES = 4).                                           |
// | Ports   : none                                                           |
// | Rev     : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_seg_to_hex_capture;

   logic CLK = 1'b0;
   logic RST;

   seg_to_hex_capture_if bus ();

   seg_to_hex_capture #(.STABLE_CYCLES(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   int         n_checks = 0;
   int         n_errors = 0;
   logic [3:0] exp_hex_q[$];   // digits expected at each VALID&&READY handshake
   logic [3:0] exp_err_q[$];   // HEX value expected while each ERR pulse is high

   // Spec writes patterns a..g left to right; the bus carries a in bit 0.
   function automatic logic [6:0] pat(input logic [6:0] abcdefg);
      logic [6:0] r;
      for (int i = 0; i < 7; i++) r[i] = abcdefg[6-i];
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic hold(input logic [6:0] s, input int n);
      bus.SEV = s;
      repeat (n) tick();
   endtask

   task automatic do_reset();
      RST = 1'b1;
      tick();
      RST = 1'b0;
      exp_hex_q.delete();
      exp_err_q.delete();
   endtask

   task automatic consume(input string name);
      bus.READY = 1'b1;
      tick();
      bus.READY = 1'b0;
      chk({name, "_valid_clr"}, bus.VALID, 1'b0);
   endtask

   // Monitor: compares every handshake and every ERR pulse with the scoreboard.
   always @(negedge CLK) begin
      if (RST === 1'b0) begin
         if (bus.VALID && bus.READY) begin
            if (exp_hex_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb_hex: unexpected handshake HEX=%0h, expected none", bus.HEX);
            end else begin
               chk("sb_hex", bus.HEX, exp_hex_q.pop_front());
            end
         end
         if (bus.ERR) begin
            if (exp_err_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL sb_err: unexpected ERR pulse, expected none");
            end else begin
               chk("sb_err_hex", bus.HEX, exp_err_q.pop_front());
            end
         end
      end
   end

   initial begin
      RST       = 1'b1;
      bus.SEV   = 7'h00;
      bus.READY = 1'b0;
      tick();
      do_reset();

      // Reset state
      chk("rst_hex",   bus.HEX,   4'h0);
      chk("rst_valid", bus.VALID, 1'b0);
      chk("rst_err",   bus.ERR,   1'b0);
      chk("rst_ovf",   bus.OVF,   1'b0);

      // Digit 3, latency of exactly four edges
      hold(pat(7'b1111001), 3);
      chk("lat3_early", bus.VALID, 1'b0);
      exp_hex_q.push_back(4'h3);
      tick();
      chk("lat3_valid", bus.VALID, 1'b1);
      chk("lat3_hex",   bus.HEX,   4'h3);
      consume("d3");

      // Interrupted run of 1 restarts the count
      hold(pat(7'b0110000), 3);
      hold(pat(7'b1101101), 1);
      hold(pat(7'b0110000), 3);
      chk("run1_early", bus.VALID, 1'b0);
      exp_hex_q.push_back(4'h1);
      tick();
      chk("run1_valid", bus.VALID, 1'b1);
      chk("run1_hex",   bus.HEX,   4'h1);
      consume("d1");

      // Illegal pattern: one-cycle ERR, HEX/VALID untouched
      exp_err_q.push_back(4'h1);
      hold(pat(7'b1010101), 4);
      chk("ill_err",   bus.ERR,   1'b1);
      chk("ill_valid", bus.VALID, 1'b0);
      chk("ill_hex",   bus.HEX,   4'h1);
      tick();
      chk("ill_err_clr", bus.ERR, 1'b0);

      // Overflow: 7 pending, E dropped
      exp_hex_q.push_back(4'h7);
      hold(pat(7'b1110000), 4);
      chk("d7_hex", bus.HEX, 4'h7);
      hold(pat(7'b1001111), 3);
      chk("ovf_early", bus.OVF, 1'b0);
      tick();
      chk("ovf_set",   bus.OVF,   1'b1);
      chk("ovf_hex",   bus.HEX,   4'h7);
      chk("ovf_valid", bus.VALID, 1'b1);
      consume("d7");
      chk("ovf_sticky", bus.OVF, 1'b1);

      // Reload on the handshake edge: A pending, F accepted with READY high
      do_reset();
      chk("rst2_ovf", bus.OVF, 1'b0);
      exp_hex_q.push_back(4'hA);
      hold(pat(7'b1110111), 4);
      chk("dA_hex", bus.HEX, 4'hA);
      hold(pat(7'b1000111), 3);
      bus.READY = 1'b1;
      exp_hex_q.push_back(4'hF);
      tick();
      bus.READY = 1'b0;
      chk("reload_valid", bus.VALID, 1'b1);
      chk("reload_hex",   bus.HEX,   4'hF);
      chk("reload_ovf",   bus.OVF,   1'b0);

      // Reset on edge 3 of a run of 8 discards pending F and the run
      hold(pat(7'b1111111), 2);
      do_reset();
      chk("mid_rst_hex",   bus.HEX,   4'h0);
      chk("mid_rst_valid", bus.VALID, 1'b0);
      chk("mid_rst_ovf",   bus.OVF,   1'b0);
      tick();
      tick();
      tick();
      chk("post_rst_early", bus.VALID, 1'b0);
      exp_hex_q.push_back(4'h8);
      tick();
      chk("post_rst_valid", bus.VALID, 1'b1);
      chk("post_rst_hex",   bus.HEX,   4'h8);
      consume("d8");

      // Glitch re-arms: same 8 emitted again after a fresh stable run
      hold(pat(7'b0110000), 1);
      hold(pat(7'b1111111), 3);
      chk("rearm_early", bus.VALID, 1'b0);
      exp_hex_q.push_back(4'h8);
      tick();
      chk("rearm_hex", bus.HEX, 4'h8);

      // BLANK is accepted silently
      bus.SEV = 7'h00;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("blank_err", bus.ERR, 1'b0);
      end
      chk("blank_valid", bus.VALID, 1'b1);
      chk("blank_hex",   bus.HEX,   4'h8);
      consume("d8b");

      tick();
      chk("sb_hex_left", exp_hex_q.size(), 0);
      chk("sb_err_left", exp_err_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_seg_to_hex_capture
`default_nettype wire

// File: doc/seg_to_hex_capture.md
SEG_TO_HEX_CAPTURE -- requirements
Module: seg_to_hex_capture

Interface
REQ-001 The block SHALL have one parameter: STABLE_CYCLES, default 4, the number of consecutive identical samples needed to accept a pattern (legal range 1..255).
REQ-002 CLK  input  1  Single clock; all state updates on the rising edge.
REQ-003 RST  input  1  Reset; synchronous and active-high.
REQ-004 SEV  input  [0:6]  Seven-segment pattern, active-high; bit 0 = segment a through bit 6 = segment g.
REQ-005 HEX  output  4  Decoded hex digit; valid while VALID is high.
REQ-006 VALID  output  1  A decoded digit is pending.
REQ-007 READY  input  1  Consumer accepts HEX on a cycle where VALID and READY are both high.
REQ-008 ERR  output  1  One-cycle pulse when a stable pattern is accepted but is not a legal digit.
REQ-009 OVF  output  1  Sticky flag: a legal digit was dropped because VALID was pending.

Function
REQ-010 Legal patterns (SEV[0:6]): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1110011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
REQ-011 BLANK is 0000000; it is neither a digit nor an error.
REQ-012 The block SHALL register SEV into prev on every edge.
REQ-013 Run counter update on every edge:
- SEV != prev: run <= 1.
- Otherwise: run <= run+1, saturating at STABLE_CYCLES.
REQ-014 The FSM SHALL have two states: UNSTABLE and LOCKED.
REQ-015 Acceptance SHALL occur on an edge where the state is UNSTABLE and the next value of run equals STABLE_CYCLES; the state SHALL then become LOCKED.
REQ-016 In LOCKED, any edge with SEV != prev SHALL return the FSM to UNSTABLE. A glitch therefore re-arms the block, and the same pattern is emitted again once it is stable.
REQ-017 Latency: a pattern first sampled on edge 1 and held SHALL be accepted on edge STABLE_CYCLES; the outputs reflect the acceptance immediately after that edge.
REQ-018 Acceptance of a legal digit with VALID low, or with VALID and READY both high on that edge: HEX <= value and VALID <= 1.
REQ-019 Acceptance of a legal digit with VALID high and READY low: the new digit SHALL be dropped, HEX SHALL remain unchanged, and OVF <= 1.
REQ-020 Acceptance of an illegal non-BLANK pattern: ERR SHALL be high for exactly the following cycle; HEX and VALID are unaffected.
REQ-021 Acceptance of BLANK SHALL change nothing other than the FSM state.
REQ-022 VALID SHALL clear on a VALID&&READY edge unless REQ-018 reloads it on the same edge.
REQ-023 HEX SHALL be stable whenever VALID is high and no handshake occurs.
REQ-024 The run counter width SHALL be $clog2(STABLE_CYCLES+1) bits; it never wraps.

Reset
REQ-025 While RST is high at an edge, the block SHALL set prev=0, run=0, state=UNSTABLE, HEX=0, VALID=0, ERR=0 and OVF=0.
REQ-026 Reset in mid-count or mid-handshake SHALL discard the pending digit. A new acceptance then requires a full STABLE_CYCLES run starting from the first edge after reset.
REQ-027 OVF SHALL clear only on reset.

Structure
REQ-028 Package seg_pkg SHALL hold:
- the 16 digit pattern constants;
- SEG_BLANK;
- the FSM state enum;
- the 7-bit segment typedef.
REQ-029 A combinational sub-module seg_decode SHALL map the 7-bit pattern to {hit, blank, value[3:0]}. It is instantiated once and used only at acceptance.

Verification
REQ-030 Scenario: STABLE_CYCLES=4, SEV=1111001 held from edge 1, READY=0 -> VALID rises after edge 4 with HEX=3; no VALID before edge 4.
REQ-031 Scenario: SEV=0110000 for 3 edges, then 1101101 for 1 edge, then 0110000 held -> no acceptance until 4 consecutive edges of 0110000, then HEX=1.
REQ-032 Scenario: SEV=1010101 held 4 edges -> ERR high for one cycle, VALID stays 0, HEX unchanged.
REQ-033 Scenario: accept 7 (1110000) with READY=0, change to E (1001111) and hold -> on E acceptance OVF=1 and HEX stays 7; then READY=1 -> VALID clears.
REQ-034 Scenario: VALID high with HEX=A, and READY=1 on the same edge that accepts F -> VALID stays 1, HEX=F, OVF stays 0.
REQ-035 Scenario: RST pulsed on edge 3 of a 4-cycle run of 1111111 -> all outputs 0; HEX=8 appears only after edge 4 counted from the first post-reset edge.
